// File: rtl/uc_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM state, owner identity and
// the default burst limit.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_CPU = 2'd1,
        ST_OWN_DMA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_e;

    localparam int unsigned MAX_BURST_DEF = 4;

endpackage

// File: rtl/uc_mem_arbiter.sv
// Two-requester (CPU / DMA loader) arbiter onto a registered single-port memory.
// Optional macro UC_ARB_LOCK_EN lets dma_lock hold the bus past the burst limit.
module uc_mem_arbiter
    import uc_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    input  logic       dma_req,
    input  logic       dma_we,
    input  logic       dma_lock,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_gnt,
    output logic       dma_rvalid,
    output logic [7:0] dma_rdata,
    output logic [7:0] mem_addr,
    output logic       mem_write_en,
    output logic       mem_rd_en,
    output logic [7:0] mem_data,
    input  logic [7:0] mem_rdata
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    arb_state_e state_q, state_d;
    owner_e     last_owner_q, last_owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       lock_hold;

    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_rd_q, mem_rd_d;

    // Read tag pipeline: stage 1 aligns with mem_rd_en, stage 2 with mem_rdata.
    logic       rd_vld1_q, rd_vld1_d, rd_vld2_q;
    owner_e     rd_own1_q, rd_own1_d, rd_own2_q;
    logic [7:0] cpu_rdata_q, dma_rdata_q;

`ifdef UC_ARB_LOCK_EN
    assign lock_hold = (state_q == ST_OWN_DMA) && dma_lock;
`else
    logic unused_dma_lock;
    assign unused_dma_lock = dma_lock;
    assign lock_hold       = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = 4'd0;
        cpu_gnt      = 1'b0;
        dma_gnt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && (!dma_req || last_owner_q == OWNER_DMA)) cpu_gnt = 1'b1;
                else if (dma_req)                                        dma_gnt = 1'b1;
            end
            ST_OWN_CPU: begin
                if (cpu_req)      cpu_gnt = 1'b1;
                else if (dma_req) dma_gnt = 1'b1;
            end
            ST_OWN_DMA: begin
                if (dma_req)      dma_gnt = 1'b1;
                else if (cpu_req) cpu_gnt = 1'b1;
            end
            default: ;
        endcase

        // The counter only runs while the other side is waiting; a fresh owner starts at 0.
        if (cpu_gnt) begin
            last_owner_d = OWNER_CPU;
            state_d      = ST_OWN_CPU;
            if (dma_req) begin
                burst_cnt_d = ((state_q == ST_OWN_CPU) ? burst_cnt_q : 4'd0) + 4'd1;
                if (burst_cnt_d >= BURST_LIM) begin
                    state_d     = ST_OWN_DMA;
                    burst_cnt_d = 4'd0;
                end
            end
        end else if (dma_gnt) begin
            last_owner_d = OWNER_DMA;
            state_d      = ST_OWN_DMA;
            if (cpu_req && !lock_hold) begin
                burst_cnt_d = ((state_q == ST_OWN_DMA) ? burst_cnt_q : 4'd0) + 4'd1;
                if (burst_cnt_d >= BURST_LIM) begin
                    state_d     = ST_OWN_CPU;
                    burst_cnt_d = 4'd0;
                end
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        mem_rd_d   = 1'b0;
        rd_vld1_d  = 1'b0;
        rd_own1_d  = OWNER_CPU;
        if (cpu_gnt) begin
            mem_addr_d = cpu_addr;
            mem_we_d   = cpu_we;
            mem_rd_d   = !cpu_we;
            rd_vld1_d  = !cpu_we;
            if (cpu_we) mem_data_d = cpu_wdata;
        end else if (dma_gnt) begin
            mem_addr_d = dma_addr;
            mem_we_d   = dma_we;
            mem_rd_d   = !dma_we;
            rd_vld1_d  = !dma_we;
            rd_own1_d  = OWNER_DMA;
            if (dma_we) mem_data_d = dma_wdata;
        end
    end

    assign cpu_rvalid = rd_vld2_q && (rd_own2_q == OWNER_CPU);
    assign dma_rvalid = rd_vld2_q && (rd_own2_q == OWNER_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_write_en = mem_we_q;
    assign mem_rd_en    = mem_rd_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_DMA;
            burst_cnt_q  <= 4'd0;
            mem_addr_q   <= 8'd0;
            mem_data_q   <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            rd_vld1_q    <= 1'b0;
            rd_own1_q    <= OWNER_CPU;
            rd_vld2_q    <= 1'b0;
            rd_own2_q    <= OWNER_CPU;
            cpu_rdata_q  <= 8'd0;
            dma_rdata_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            mem_rd_q     <= mem_rd_d;
            rd_vld1_q    <= rd_vld1_d;
            rd_own1_q    <= rd_own1_d;
            rd_vld2_q    <= rd_vld1_q;
            rd_own2_q    <= rd_own1_q;
            cpu_rdata_q  <= cpu_rdata;
            dma_rdata_q  <= dma_rdata;
        end
    end

endmodule

// File: tb/tb_uc_mem_arbiter.sv
// Scoreboard bench for uc_mem_arbiter: grants are checked per scenario, memory
// port and read returns are checked against queued expectations.
module tb_uc_mem_arbiter;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [7:0] cpu_rdata, dma_rdata;
    logic [7:0] mem_addr, mem_data;
    logic       mem_write_en, mem_rd_en;
    logic [7:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {int due; logic we; logic [7:0] addr; logic [7:0] data;} mem_exp_t;
    typedef struct {int due; logic dma; logic [7:0] data;} rd_exp_t;
    mem_exp_t mq[$];
    rd_exp_t  rq[$];
    mem_exp_t mon_me;
    rd_exp_t  mon_re;
    logic [7:0] last_addr, last_data, last_crd, last_drd;
    logic [7:0] memarr [256];

    uc_mem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .arst_n(arst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_rd_en(mem_rd_en),
        .mem_data(mem_data), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h4A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Memory model: one-cycle read latency after mem_rd_en.
    initial begin
        for (int i = 0; i < 256; i++) memarr[i] = init_val(8'(i));
        mem_rdata = 8'd0;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en)    mem_rdata <= memarr[mem_addr];
        if (mem_write_en) memarr[mem_addr] <= mem_data;
    end

    always @(negedge clk) begin
        if (arst_n) begin
            check("gnt_excl", 32'(cpu_gnt & dma_gnt), 32'd0);
            if (mq.size() > 0 && mq[0].due == cyc) begin
                mon_me = mq.pop_front();
                check("mem_we", 32'(mem_write_en), 32'(mon_me.we));
                check("mem_rd", 32'(mem_rd_en), 32'(!mon_me.we));
                check("mem_addr", 32'(mem_addr), 32'(mon_me.addr));
                last_addr = mon_me.addr;
                if (mon_me.we) last_data = mon_me.data;
            end else begin
                check("mem_we_idle", 32'(mem_write_en), 32'd0);
                check("mem_rd_idle", 32'(mem_rd_en), 32'd0);
                check("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
            end
            check("mem_data", 32'(mem_data), 32'(last_data));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mon_re = rq.pop_front();
                check("cpu_rvalid", 32'(cpu_rvalid), 32'(!mon_re.dma));
                check("dma_rvalid", 32'(dma_rvalid), 32'(mon_re.dma));
                if (mon_re.dma) last_drd = mon_re.data;
                else            last_crd = mon_re.data;
            end else begin
                check("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
                check("dma_rvalid_idle", 32'(dma_rvalid), 32'd0);
            end
            check("cpu_rdata", 32'(cpu_rdata), 32'(last_crd));
            check("dma_rdata", 32'(dma_rdata), 32'(last_drd));
            if (cpu_gnt) begin
                mq.push_back('{cyc + 1, cpu_we, cpu_addr, cpu_wdata});
                if (!cpu_we) rq.push_back('{cyc + 2, 1'b0, init_val(cpu_addr)});
            end else if (dma_gnt) begin
                mq.push_back('{cyc + 1, dma_we, dma_addr, dma_wdata});
                if (!dma_we) rq.push_back('{cyc + 2, 1'b1, init_val(dma_addr)});
            end
        end
    end

    task automatic zero_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic flush_model();
        mq.delete(); rq.delete();
        last_addr = 0; last_data = 0; last_crd = 0; last_drd = 0;
    endtask

    task automatic apply_reset();
        zero_inputs();
        arst_n = 1'b0;
        flush_model();
        repeat (2) @(negedge clk);
        #2 arst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; zero_inputs(); end
    endtask

    task automatic cpu_single(input logic we, input logic [7:0] a, input logic [7:0] d, input string tag);
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        check(tag, 32'(cpu_gnt), 32'd1);
        @(posedge clk); #1; zero_inputs();
    endtask

    int nd, nc, dma_before;
    logic cpu_done;

    initial begin
        zero_inputs();
        flush_model();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_gnt", 32'(cpu_gnt), 0);
        check("rst_dma_gnt", 32'(dma_gnt), 0);
        check("rst_mem_rd", 32'(mem_rd_en), 0);
        check("rst_mem_we", 32'(mem_write_en), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_rdata", 32'({cpu_rdata, dma_rdata, cpu_rvalid, dma_rvalid}), 0);
        #2 arst_n = 1'b1;

        // CPU read of 0x10: grant, memory port, then data two cycles after grant
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        check("r030_cpu_gnt", 32'(cpu_gnt), 1);
        check("r030_dma_gnt", 32'(dma_gnt), 0);
        @(posedge clk); #1; zero_inputs();
        @(negedge clk);
        check("r030_mem_rd", 32'(mem_rd_en), 1);
        check("r030_mem_addr", 32'(mem_addr), 32'h10);
        @(posedge clk); #1;
        @(negedge clk);
        check("r030_rvalid", 32'(cpu_rvalid), 1);
        check("r030_rdata", 32'(cpu_rdata), 32'h5A);
        idle(2);

        // Tie after reset goes to CPU; next tie after CPU ran goes to DMA
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            zero_inputs();
            if (k != 2) begin
                cpu_req = 1; cpu_addr = 8'h20; dma_req = 1; dma_addr = 8'h21;
            end
            @(negedge clk);
            check("r031_gnt", 32'({cpu_gnt, dma_gnt}),
                  (k == 2) ? 32'd0 : (k == 3) ? 32'b01 : 32'b10);
        end
        idle(3);

        // DMA writes 0..7 against continuous CPU reads: 4/4 alternation
        apply_reset();
        cpu_single(1'b0, 8'h11, 8'h00, "r032_pre_gnt");
        idle(1);
        nd = 0; nc = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40 + 8'(nc);
            dma_req = (nd < 8); dma_we = 1; dma_addr = 8'(nd); dma_wdata = 8'(nd);
            @(negedge clk);
            check("r032_gnt", 32'({cpu_gnt, dma_gnt}), (((k / 4) % 2) == 0) ? 32'b01 : 32'b10);
            if (dma_gnt) nd++;
            if (cpu_gnt) nc++;
        end
        check("r032_dma_cnt", 32'(nd), 32'd8);
        idle(3);

        // DMA lock: 8 writes with CPU pending
        cpu_single(1'b0, 8'h13, 8'h00, "r033_pre_gnt");
        idle(1);
        nd = 0; dma_before = 0; cpu_done = 0;
        for (int k = 0; k < 40 && !(cpu_done && nd >= 8); k++) begin
            @(posedge clk); #1;
            cpu_req = !cpu_done; cpu_we = 0; cpu_addr = 8'h50;
            dma_req = (nd < 8); dma_we = 1; dma_lock = 1;
            dma_addr = 8'h80 + 8'(nd); dma_wdata = 8'hC0 + 8'(nd);
            @(negedge clk);
            if (dma_gnt) begin nd++; if (!cpu_done) dma_before++; end
            if (cpu_gnt) cpu_done = 1;
        end
        check("r033_done", 32'({cpu_done, nd >= 8}), 32'b11);
`ifdef UC_ARB_LOCK_EN
        check("r033_dma_before_cpu", 32'(dma_before), 32'd8);
`else
        check("r033_dma_before_cpu", 32'(dma_before), 32'd4);
`endif
        idle(3);

        // Write 0xA5: one write-enable cycle, then held
        cpu_single(1'b1, 8'h30, 8'hA5, "r034_gnt");
        @(negedge clk);
        check("r034_we", 32'(mem_write_en), 1);
        check("r034_data", 32'(mem_data), 32'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        check("r034_we_off", 32'(mem_write_en), 0);
        check("r034_data_hold", 32'(mem_data), 32'hA5);
        idle(2);

        // Reset one cycle after a granted read discards it
        cpu_single(1'b0, 8'h12, 8'h00, "r035_gnt");
        #1 arst_n = 1'b0;
        flush_model();
        #1;
        check("r035_mem_rd", 32'(mem_rd_en), 0);
        check("r035_mem_addr", 32'(mem_addr), 0);
        check("r035_mem_data", 32'(mem_data), 0);
        check("r035_rvalid", 32'({cpu_rvalid, dma_rvalid}), 0);
        repeat (2) @(negedge clk);
        #2 arst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("r035_no_rvalid", 32'(cpu_rvalid), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
